// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: pattern, per-LED blink mask, blink period and
// global PWM brightness, all CPU read/write, driving a registered lights vector.
module led_ctrl #(
    parameter int NLEDS      = 16,
    parameter int Dbits      = 32,
    parameter int BLINK_BITS = 24,
    parameter int PWM_BITS   = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [1:0]       addr,
    input  logic [Dbits-1:0] cpu_writedata,
    output logic [Dbits-1:0] cpu_readdata,
    output logic [NLEDS-1:0] lights
);

    localparam logic [1:0] ADDR_LEDS     = 2'd0;
    localparam logic [1:0] ADDR_BLINK_EN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_DUTY     = 2'd3;

    logic [NLEDS-1:0]      leds_q, leds_d;
    logic [NLEDS-1:0]      blink_en_q, blink_en_d;
    logic [BLINK_BITS-1:0] blink_period_q, blink_period_d;
    logic [PWM_BITS-1:0]   duty_q, duty_d;
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [NLEDS-1:0]      lights_q, lights_d;
    logic                  pwm_on;
    logic                  period_wr;
    logic                  unused_wdata;

    // wr is a single-cycle write strobe with no back-pressure: the register
    // selected by addr is updated at every rising edge where wr is high.
    assign period_wr    = wr && (addr == ADDR_PERIOD);
    assign unused_wdata = ^cpu_writedata;

    always_comb begin
        leds_d         = leds_q;
        blink_en_d     = blink_en_q;
        blink_period_d = blink_period_q;
        duty_d         = duty_q;
        if (wr) begin
            case (addr)
                ADDR_LEDS:     leds_d         = cpu_writedata[NLEDS-1:0];
                ADDR_BLINK_EN: blink_en_d     = cpu_writedata[NLEDS-1:0];
                ADDR_PERIOD:   blink_period_d = cpu_writedata[BLINK_BITS-1:0];
                ADDR_DUTY:     duty_d         = cpu_writedata[PWM_BITS-1:0];
                default:       leds_d         = leds_q;
            endcase
        end
    end

    // Full-scale duty is forced on so maximum brightness has no dark slot.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = (&duty_q) || (pwm_cnt_q < duty_q);
    end

    // A period write restarts the blink cleanly even if the new period is
    // already below the running count.
    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        phase_d     = phase_q;
        if (period_wr || (blink_period_q == '0)) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == blink_period_q) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    always_comb begin
        lights_d = leds_q & {NLEDS{pwm_on}} & (~blink_en_q | {NLEDS{phase_q}});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            leds_q         <= '0;
            blink_en_q     <= '0;
            blink_period_q <= '0;
            duty_q         <= '1;
            pwm_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            phase_q        <= 1'b1;
            lights_q       <= '0;
        end else begin
            leds_q         <= leds_d;
            blink_en_q     <= blink_en_d;
            blink_period_q <= blink_period_d;
            duty_q         <= duty_d;
            pwm_cnt_q      <= pwm_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            phase_q        <= phase_d;
            lights_q       <= lights_d;
        end
    end

    always_comb begin
        cpu_readdata = '0;
        case (addr)
            ADDR_LEDS:     cpu_readdata[NLEDS-1:0]      = leds_q;
            ADDR_BLINK_EN: cpu_readdata[NLEDS-1:0]      = blink_en_q;
            ADDR_PERIOD:   cpu_readdata[BLINK_BITS-1:0] = blink_period_q;
            ADDR_DUTY:     cpu_readdata[PWM_BITS-1:0]   = duty_q;
            default:       cpu_readdata                 = '0;
        endcase
    end

    assign lights = lights_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: reset values, readback truncation, PWM duty,
// blink timing, period restart and asynchronous reset.
module tb_led_ctrl;

    logic        clock;
    logic        reset_n;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic [15:0] lights;

    int checks = 0;
    int errors = 0;

    led_ctrl #(.NLEDS(16), .Dbits(32), .BLINK_BITS(24), .PWM_BITS(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wr            (wr),
        .addr          (addr),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .lights        (lights)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr          = a;
        cpu_writedata = d;
        wr            = 1'b1;
        @(posedge clock);
        #1;
        wr = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, cpu_readdata, exp);
    endtask

    // Blink phase after the j-th edge following a period write of p.
    function automatic bit phase_at(input int j, input int p);
        return ((j / (p + 1)) % 2) == 0;
    endfunction

    task automatic check_reset_regs(input string pfx);
        read_check({pfx, "_leds"},   2'd0, 32'h0);
        read_check({pfx, "_blinken"}, 2'd1, 32'h0);
        read_check({pfx, "_period"}, 2'd2, 32'h0);
        read_check({pfx, "_duty"},   2'd3, 32'hFF);
    endtask

    task automatic default_scenario(input string pfx, input int steady);
        int bad;
        bus_write(2'd0, 32'h0000_A5C3);
        check({pfx, "_lat_edge1"}, {16'h0, lights}, 32'h0);
        tick();
        check({pfx, "_lat_edge2"}, {16'h0, lights}, 32'h0000_A5C3);
        bad = 0;
        for (int i = 0; i < steady; i++) begin
            tick();
            if (lights !== 16'hA5C3) bad++;
        end
        check({pfx, "_steady_bad"}, bad, 0);
    endtask

    task automatic restart_check(input string tag, input int w);
        int bad;
        bus_write(2'd2, 32'd99);
        repeat (w) tick();
        bus_write(2'd2, 32'd3);
        bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) check({tag, "_first"}, {16'h0, lights}, 32'h00FF);
            if (lights !== (phase_at(k - 1, 3) ? 16'h00FF : 16'h00F0)) bad++;
        end
        check({tag, "_bad"}, bad, 0);
    endtask

    initial begin
        int hi;
        int bad;
        int guard;
        reset_n       = 1'b0;
        wr            = 1'b0;
        addr          = 2'd0;
        cpu_writedata = 32'h0;

        // Reset held
        #2;
        check("rst_lights", {16'h0, lights}, 32'h0);
        check_reset_regs("rst");
        repeat (2) tick();
        check("rst_lights_clk", {16'h0, lights}, 32'h0);
        reset_n = 1'b1;
        default_scenario("dflt", 1000);

        // Readback truncation
        bus_write(2'd0, 32'h1234_5678);
        read_check("rd_leds", 2'd0, 32'h0000_5678);
        bus_write(2'd1, 32'h1234_5678);
        read_check("rd_blinken", 2'd1, 32'h0000_5678);
        bus_write(2'd2, 32'h1234_5678);
        read_check("rd_period", 2'd2, 32'h0034_5678);
        bus_write(2'd3, 32'h1234_5678);
        read_check("rd_duty", 2'd3, 32'h0000_0078);
        read_check("rd_leds_kept", 2'd0, 32'h0000_5678);

        // PWM
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'h0);
        bus_write(2'd0, 32'hFFFF);
        bus_write(2'd3, 32'd64);
        hi = 0; bad = 0;
        repeat (256) begin
            tick();
            if (lights === 16'hFFFF) hi++;
            else if (lights !== 16'h0) bad++;
        end
        check("pwm64_high", hi, 64);
        check("pwm64_partial", bad, 0);

        bus_write(2'd3, 32'd0);
        bad = 0;
        repeat (256) begin
            tick();
            if (lights !== 16'h0) bad++;
        end
        check("pwm0_bad", bad, 0);

        bus_write(2'd3, 32'd255);
        bad = 0;
        repeat (256) begin
            tick();
            if (lights !== 16'hFFFF) bad++;
        end
        check("pwm255_bad", bad, 0);

        // Blink, P=9
        bus_write(2'd0, 32'h00FF);
        bus_write(2'd1, 32'h000F);
        bus_write(2'd2, 32'd9);
        bad = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 10) check("blink_k10", {16'h0, lights}, 32'h00FF);
            if (k == 11) check("blink_k11", {16'h0, lights}, 32'h00F0);
            if (k == 21) check("blink_k21", {16'h0, lights}, 32'h00FF);
            if (lights !== (phase_at(k - 1, 9) ? 16'h00FF : 16'h00F0)) bad++;
        end
        check("blink_bad", bad, 0);

        // Period restart from a high count, in each phase
        restart_check("restart50", 50);
        restart_check("restart120", 120);

        // Async reset while blinking and dimming
        bus_write(2'd3, 32'd128);
        guard = 0;
        while (lights === 16'h0 && guard < 50) begin
            tick();
            guard++;
        end
        check("pre_rst_nonzero", {31'h0, lights !== 16'h0}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_lights", {16'h0, lights}, 32'h0);
        check_reset_regs("async");
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
        default_scenario("post_rst", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
